// File: rtl/correlator_readout.sv
// Freezes the correlator's packed I/Q accumulators on a capture strobe and streams
// them out as a byte frame over valid/ready. Define READOUT_CHECKSUM_EN for a trailing XOR byte.
module correlator_readout #(
    parameter int          NUM_BASELINES = 8,
    parameter int          RESOLUTION    = 24,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [NUM_BASELINES*RESOLUTION*2-1:0] pulses,
    input  logic                                  capture,
    output logic                                  corr_clear,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int PW     = NUM_BASELINES * RESOLUTION * 2;
    localparam int BPW    = (RESOLUTION + 7) / 8;
    localparam int NWORDS = 2 * NUM_BASELINES;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     snapshot_q;
    logic              load_snap;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              corr_clear_q, corr_clear_d;
    logic              overrun_q, overrun_d;
    logic              handshake;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Word w is baseline w/2, I for even w and Q for odd w; byte b counts from the MSB
    // of the word after zero-extension to BPW bytes.
    function automatic logic [7:0] word_byte(input logic [PW-1:0]     snap,
                                             input logic [WIDX_W-1:0] w,
                                             input logic [BIDX_W-1:0] b);
        logic [PW-1:0]      shifted;
        logic [BPW*8-1:0]   ext;
        int                 base;
        int                 lo;
        base    = (NUM_BASELINES - 1 - int'(w >> 1)) * 2 * RESOLUTION
                  + int'(w[0]) * RESOLUTION;
        shifted = snap >> base;
        ext     = '0;
        ext[RESOLUTION-1:0] = shifted[RESOLUTION-1:0];
        lo      = (BPW - 1 - int'(b)) * 8;
        return ext[lo +: 8];
    endfunction

    assign handshake  = tx_valid_q & tx_ready;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign corr_clear = corr_clear_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        seq_d        = seq_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        corr_clear_d = 1'b0;
        overrun_d    = overrun_q;
        load_snap    = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        csum_d       = csum_q;
        if (handshake) begin
            csum_d = csum_q ^ tx_data_q;
        end
`endif

        case (state_q)
            IDLE: begin
                if (capture && enable) begin
                    state_d      = SYNC;
                    tx_data_d    = SYNC_BYTE;
                    tx_valid_d   = 1'b1;
                    corr_clear_d = 1'b1;
                    load_snap    = 1'b1;
`ifdef READOUT_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            SYNC: begin
                if (handshake) begin
                    state_d   = SEQ;
                    tx_data_d = seq_q;
                end
            end
            SEQ: begin
                if (handshake) begin
                    state_d    = DATA;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    tx_data_d  = word_byte(snapshot_q, '0, '0);
                end
            end
            DATA: begin
                if (handshake) begin
                    if (word_idx_q == LAST_WORD && byte_idx_q == LAST_BYTE) begin
                        seq_d = seq_q + 8'd1;
`ifdef READOUT_CHECKSUM_EN
                        state_d   = CSUM;
                        tx_data_d = csum_q ^ tx_data_q;
`else
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
`endif
                    end else begin
                        if (byte_idx_q == LAST_BYTE) begin
                            byte_idx_d = '0;
                            word_idx_d = word_idx_q + WIDX_W'(1);
                        end else begin
                            byte_idx_d = byte_idx_q + BIDX_W'(1);
                        end
                        tx_data_d = word_byte(snapshot_q, word_idx_d, byte_idx_d);
                    end
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // A capture that arrives while a frame is still out (including its last handshake) is lost.
        if (state_q != IDLE && capture && enable) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            seq_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            corr_clear_q <= 1'b0;
            overrun_q    <= 1'b0;
            snapshot_q   <= '0;
`ifdef READOUT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            seq_q        <= seq_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            corr_clear_q <= corr_clear_d;
            overrun_q    <= overrun_d;
            if (load_snap) begin
                snapshot_q <= pulses;
            end
`ifdef READOUT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_correlator_readout.sv
// Self-checking bench for correlator_readout: a frame model feeds a byte scoreboard;
// table vectors plus hand-written overrun, reset, wrap and enable sequences.
module tb_correlator_readout;

    localparam int NB  = 8;
    localparam int R   = 24;
    localparam int BPW = 3;
    localparam int W   = NB * R * 2;
`ifdef READOUT_CHECKSUM_EN
    localparam int FRAME_LEN = 2 + 2 * NB * BPW + 1;
`else
    localparam int FRAME_LEN = 2 + 2 * NB * BPW;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] pulses;
    logic         capture;
    logic         corr_clear;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         overrun;

    correlator_readout dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pulses     (pulses),
        .capture    (capture),
        .corr_clear (corr_clear),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] i0;
        logic [23:0] q0;
        logic [23:0] fill;
        int          mode;
        logic [7:0]  exp_csum;
    } vec_t;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq    = 8'h00;
    int         hs_count   = 0;
    int         frame_start = 0;
    logic [7:0] last_byte  = 8'h00;
    logic       stalled    = 1'b0;
    logic [7:0] stall_data = 8'h00;
    vec_t       vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && tx_valid) checkOutput("stall_hold", tx_data, stall_data);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL extra_byte: got %0h, expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tx_byte", tx_data, e);
                end
                hs_count++;
                last_byte = tx_data;
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setReady(input int mode, input int c);
        case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Loads pulses with baseline 0 = (i0,q0), all others = fill, and queues the expected frame.
    task automatic applyStimulus(input logic [23:0] i0, input logic [23:0] q0, input logic [23:0] fill);
        logic [7:0]  cs;
        logic [23:0] w;
        logic [7:0]  b;
        pulses = '0;
        for (int a = 0; a < NB; a++) begin
            pulses[(NB-a-1)*2*R +: R]     = (a == 0) ? i0 : fill;
            pulses[(NB-a-1)*2*R + R +: R] = (a == 0) ? q0 : fill;
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(exp_seq);
        cs = 8'hA5 ^ exp_seq;
        for (int a = 0; a < NB; a++) begin
            for (int iq = 0; iq < 2; iq++) begin
                w = (a == 0) ? ((iq == 0) ? i0 : q0) : fill;
                for (int k = 0; k < BPW; k++) begin
                    b = w[(BPW-1-k)*8 +: 8];
                    exp_q.push_back(b);
                    cs = cs ^ b;
                end
            end
        end
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic doCapture();
        frame_start = hs_count;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        checkOutput("clear_after_capture", corr_clear, 1'b1);
        checkOutput("busy_after_capture", busy, 1'b1);
        checkOutput("valid_after_capture", tx_valid, 1'b1);
        checkOutput("sync_byte", tx_data, 8'hA5);
    endtask

    task automatic runFrame(input int mode);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 4000) begin
            setReady(mode, c);
            tick();
            if (c == 0) checkOutput("clear_one_cycle", corr_clear, 1'b0);
            c++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL frame_timeout: %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        checkOutput("busy_after_frame", busy, 1'b0);
        checkOutput("valid_after_frame", tx_valid, 1'b0);
        checkOutput("frame_len", hs_count - frame_start, FRAME_LEN);
    endtask

    initial begin
        vecs[0] = '{i0: 24'h123456, q0: 24'h000001, fill: 24'h000000, mode: 0, exp_csum: 8'hD4};
        vecs[1] = '{i0: 24'h123456, q0: 24'h000001, fill: 24'h000000, mode: 1, exp_csum: 8'hD5};
        vecs[2] = '{i0: 24'h000000, q0: 24'h000000, fill: 24'hFFFFFF, mode: 0, exp_csum: 8'hA7};
        vecs[3] = '{i0: 24'hABCDEF, q0: 24'hFEDCBA, fill: 24'h000000, mode: 2, exp_csum: 8'hB7};

        reset = 1'b1; enable = 1'b0; capture = 1'b0; tx_ready = 1'b0; pulses = '0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_corr_clear", corr_clear, 1'b0);
        checkOutput("reset_tx_valid", tx_valid, 1'b0);
        checkOutput("reset_tx_data", tx_data, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);

        // Captures with enable low are ignored entirely.
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            capture = 1'b1;
            tick();
            capture = 1'b0;
            checkOutput("dis_corr_clear", corr_clear, 1'b0);
            checkOutput("dis_busy", busy, 1'b0);
            tick();
            checkOutput("dis_tx_valid", tx_valid, 1'b0);
            checkOutput("dis_overrun", overrun, 1'b0);
        end
        enable = 1'b1;

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].i0, vecs[v].q0, vecs[v].fill);
            doCapture();
            // Scramble pulses after capture: the snapshot must not follow it.
            pulses = {12{32'hDEADBEEF}};
            runFrame(vecs[v].mode);
`ifdef READOUT_CHECKSUM_EN
            checkOutput("csum_byte", last_byte, vecs[v].exp_csum);
`endif
        end

        // Second capture mid-frame: dropped, overrun sticks, no clear pulse.
        applyStimulus(24'h0F0F0F, 24'h00F00F, 24'h010203);
        doCapture();
        tx_ready = 1'b1;
        repeat (5) tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        checkOutput("ovr_corr_clear", corr_clear, 1'b0);
        checkOutput("ovr_set", overrun, 1'b1);
        checkOutput("ovr_busy", busy, 1'b1);
        runFrame(0);
        checkOutput("ovr_sticky", overrun, 1'b1);
        applyStimulus(24'h000100, 24'h800000, 24'h000000);
        doCapture();
        runFrame(1);
        checkOutput("ovr_sticky2", overrun, 1'b1);

        // Reset after byte 10 abandons the frame.
        applyStimulus(24'h111111, 24'h222222, 24'h333333);
        doCapture();
        tx_ready = 1'b1;
        for (int c = 0; c < 100 && (hs_count - frame_start) < 10; c++) tick();
        reset = 1'b1;
        tx_ready = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_overrun", overrun, 1'b0);
        exp_q.delete();
        exp_seq = 8'h00;
        tx_ready = 1'b1;
        tick();
        checkOutput("rst_no_resume", tx_valid, 1'b0);

        // Fresh frame restarts at seq 00; capture lands on its final handshake.
        applyStimulus(24'h123456, 24'h000001, 24'h000000);
        doCapture();
        for (int c = 0; c < 200 && exp_q.size() > 1; c++) tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        checkOutput("edge_busy", busy, 1'b0);
        checkOutput("edge_tx_valid", tx_valid, 1'b0);
        checkOutput("edge_corr_clear", corr_clear, 1'b0);
        checkOutput("edge_overrun", overrun, 1'b1);
        checkOutput("edge_frame_len", hs_count - frame_start, FRAME_LEN);
        tick();
        checkOutput("edge_no_frame", busy, 1'b0);

        // Back-to-back frames through the sequence wrap (seq 01..FF, 00, 01).
        for (int k = 0; k < 257; k++) begin
            applyStimulus(24'(k * 24'h010101), 24'(~k), 24'(k));
            doCapture();
            runFrame(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
